// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file write-back stage: result word, source tag
// and the register-address-to-mask helper used by the hazard logic.
package rf_wb_pkg;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NREG = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;

  typedef enum logic {SRC_ALU, SRC_LD} wb_src_e;

  function automatic logic [NREG-1:0] rd_bit(input logic [AW-1:0] rd);
    rd_bit = '0;
    rd_bit[rd] = 1'b1;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Small per-producer result FIFO; also exposes which slots are occupied and the
// destination register held in each slot so the top can build the pending mask.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int  QDEPTH = 2,
  parameter type T      = wb_req_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output T                           head,
  output logic [QDEPTH-1:0]          vld,
  output logic [QDEPTH-1:0][AW-1:0]  ent_rd
);
  localparam int PW = $clog2(QDEPTH);

  logic [PW-1:0]       wptr_q, rptr_q;
  logic [PW:0]         cnt_q;
  T [QDEPTH-1:0]       mem_q;
  logic                do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(QDEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      mem_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] off;
    vld = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      off       = PW'(i) - rptr_q;
      vld[i]    = ({1'b0, off} < cnt_q);
      ent_rd[i] = mem_q[i].rd;
    end
  end
endmodule

// File: rtl/rf_writeback.sv
// Write-back stage: queues ALU and load results, arbitrates ALU-first with a
// starvation limit for loads, and drives the register-file write port.
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [DW-1:0]   alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [DW-1:0]   ld_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_ptr_w,
  output logic [DW-1:0]   rf_di,
  output logic [NREG-1:0] pend_mask,
  output logic            busy
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_req_t                    alu_head, ld_head, win;
  logic                       alu_full, alu_empty, ld_full, ld_empty;
  logic                       alu_pop, ld_pop, wr_d;
  logic [QDEPTH-1:0]          alu_vld, ld_vld;
  logic [QDEPTH-1:0][AW-1:0]  alu_ent, ld_ent;
  wb_src_e                    src;
  logic [SW-1:0]              starve_q, starve_d;
  logic                       rf_we_q;
  logic [AW-1:0]              rf_ptr_q;
  logic [DW-1:0]              rf_di_q;
  logic [NREG-1:0]            pend;

  assign alu_ready = !alu_full && rst_n;
  assign ld_ready  = !ld_full && rst_n;

  wb_fifo #(.QDEPTH(QDEPTH), .T(wb_req_t)) u_alu_q (
    .clk(clk), .rst_n(rst_n),
    .push(alu_valid && alu_ready), .din('{rd: alu_rd, data: alu_data}),
    .pop(alu_pop), .full(alu_full), .empty(alu_empty), .head(alu_head),
    .vld(alu_vld), .ent_rd(alu_ent)
  );

  wb_fifo #(.QDEPTH(QDEPTH), .T(wb_req_t)) u_ld_q (
    .clk(clk), .rst_n(rst_n),
    .push(ld_valid && ld_ready), .din('{rd: ld_rd, data: ld_data}),
    .pop(ld_pop), .full(ld_full), .empty(ld_empty), .head(ld_head),
    .vld(ld_vld), .ent_rd(ld_ent)
  );

  // Loads win only when the ALU is idle or has used up its starvation budget.
  always_comb begin
    alu_pop  = 1'b0;
    ld_pop   = 1'b0;
    src      = SRC_ALU;
    starve_d = starve_q;
    if (!ld_empty && (alu_empty || starve_q == SW'(STARVE_MAX))) begin
      ld_pop = 1'b1;
      src    = SRC_LD;
    end else if (!alu_empty) begin
      alu_pop = 1'b1;
    end
    if (ld_empty || ld_pop) starve_d = '0;
    else if (alu_pop)       starve_d = starve_q + SW'(1);
  end

  assign wr_d = alu_pop || ld_pop;
  assign win  = (src == SRC_LD) ? ld_head : alu_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q  <= 1'b0;
      rf_ptr_q <= '0;
      rf_di_q  <= '0;
      starve_q <= '0;
    end else begin
      rf_we_q  <= wr_d;
      starve_q <= starve_d;
      if (wr_d) begin
        rf_ptr_q <= win.rd;
        rf_di_q  <= win.data;
      end
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (alu_vld[i]) pend = pend | rd_bit(alu_ent[i]);
      if (ld_vld[i])  pend = pend | rd_bit(ld_ent[i]);
    end
    if (rf_we_q) pend = pend | rd_bit(rf_ptr_q);
  end

  assign rf_we     = rf_we_q;
  assign rf_ptr_w  = rf_ptr_q;
  assign rf_di     = rf_di_q;
  assign pend_mask = pend;
  assign busy      = |pend;

  // The decoder's hazard stall guarantees distinct targets at the two heads.
  a_heads_distinct: assert property (@(posedge clk) disable iff (!rst_n)
    !(!alu_empty && !ld_empty && alu_head.rd == ld_head.rd));
endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed scenarios plus random traffic, all compared
// each cycle against a queue-based reference model of the write-back stage.
module tb_rf_writeback;
  import rf_wb_pkg::*;
  localparam int QD   = 2;
  localparam int SMAX = 3;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            alu_valid = 1'b0, ld_valid = 1'b0;
  logic [AW-1:0]   alu_rd = '0, ld_rd = '0;
  logic [DW-1:0]   alu_data = '0, ld_data = '0;
  logic            alu_ready, ld_ready, rf_we, busy;
  logic [AW-1:0]   rf_ptr_w;
  logic [DW-1:0]   rf_di;
  logic [NREG-1:0] pend_mask;

  rf_writeback #(.QDEPTH(QD), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rf_we(rf_we), .rf_ptr_w(rf_ptr_w), .rf_di(rf_di),
    .pend_mask(pend_mask), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model state: what sits in each queue and on the rf port.
  wb_req_t       aq[$], lq[$];
  int            starve = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_ptr = '0;
  logic [DW-1:0] m_di = '0;
  int            wlog[$];
  int            checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] m_pend();
    logic [NREG-1:0] m = '0;
    foreach (aq[i]) m[aq[i].rd] = 1'b1;
    foreach (lq[i]) m[lq[i].rd] = 1'b1;
    if (m_we) m[m_ptr] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    aq.delete(); lq.delete();
    starve = 0; m_we = 1'b0; m_ptr = '0; m_di = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit acc_a, acc_l, an, ln;
    wb_req_t w;
    acc_a = rst_n && alu_valid && (aq.size() < QD);
    acc_l = rst_n && ld_valid && (lq.size() < QD);
    an = aq.size() > 0;
    ln = lq.size() > 0;
    if (an && !(ln && starve == SMAX)) begin
      w = aq.pop_front(); starve = ln ? starve + 1 : 0; m_we = 1'b1;
    end else if (ln) begin
      w = lq.pop_front(); starve = 0; m_we = 1'b1;
    end else begin
      m_we = 1'b0; starve = 0;
    end
    if (m_we) begin m_ptr = w.rd; m_di = w.data; end
    if (acc_a) aq.push_back('{rd: alu_rd, data: alu_data});
    if (acc_l) lq.push_back('{rd: ld_rd, data: ld_data});
  endtask

  task automatic check_outs();
    chk("rf_we", rf_we, m_we);
    chk("rf_ptr_w", rf_ptr_w, m_ptr);
    chk("rf_di", rf_di, m_di);
    chk("pend_mask", pend_mask, m_pend());
    chk("busy", busy, |m_pend());
    chk("alu_ready", alu_ready, rst_n && (aq.size() < QD));
    chk("ld_ready", ld_ready, rst_n && (lq.size() < QD));
    if (rf_we === 1'b1) wlog.push_back(int'(rf_ptr_w));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle(input int n);
    alu_valid = 1'b0; ld_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drive(input bit av, input int ar, input int ad, input bit lv, input int lr, input int ld);
    alu_valid = av; alu_rd = AW'(ar); alu_data = DW'(ad);
    ld_valid = lv;  ld_rd = AW'(lr);  ld_data = DW'(ld);
  endtask

  task automatic chk_log(input string tag, input int exp[]);
    chk({tag, "_count"}, wlog.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk(tag, (i < wlog.size()) ? wlog[i] : -1, exp[i]);
  endtask

  function automatic int pick(input logic [NREG-1:0] fr);
    int n = $urandom_range(0, NREG - 1);
    for (int k = 0; k < NREG; k++)
      if (fr[(n + k) % NREG]) return (n + k) % NREG;
    return 0;
  endfunction

  initial begin
    logic [NREG-1:0] fr;

    // 1: reset state, single ALU write
    #2;
    check_outs();
    chk("rst_pend", pend_mask, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 8'h3C, 0, 0, 0);
    tick();
    chk("t1_pend_acc", pend_mask, 4'b0010);
    idle(1);
    chk("t1_we", rf_we, 1);
    chk("t1_ptr", rf_ptr_w, 1);
    chk("t1_di", rf_di, 8'h3C);
    chk("t1_pend", pend_mask, 4'b0010);
    idle(2);

    // 2: burst across both producers
    wlog.delete();
    drive(1, 0, 8'h10, 1, 2, 8'h20); tick();
    drive(1, 1, 8'h11, 0, 0, 0);     tick();
    idle(4);
    chk_log("t2_order", '{0, 1, 2});

    // 3: ALU every cycle, one load waiting -> load after three ALU wins
    wlog.delete();
    drive(1, 0, 8'hA0, 1, 3, 8'hB3); tick();
    drive(1, 1, 8'hA1, 0, 0, 0);     tick();
    drive(1, 2, 8'hA2, 0, 0, 0);     tick();
    drive(1, 0, 8'hA3, 0, 0, 0);     tick();
    drive(1, 1, 8'hA4, 0, 0, 0);     tick();
    chk("t3_alu_full", alu_ready, 0);
    idle(5);
    chk_log("t3_order", '{0, 1, 2, 3, 0, 1});

    // 4: fill the load queue and offer more while it is full
    wlog.delete();
    drive(1, 0, 8'hC0, 1, 2, 8'hD2); tick();
    drive(1, 1, 8'hC1, 1, 3, 8'hD3); tick();
    chk("t4_ld_full", ld_ready, 0);
    drive(0, 0, 0, 1, 0, 8'h55);     tick();
    chk("t4_ld_full2", ld_ready, 0);
    idle(5);
    chk_log("t4_order", '{0, 1, 2, 3});

    // 5: reset with writes queued
    wlog.delete();
    drive(1, 0, 8'hE0, 1, 2, 8'hF2); tick();
    drive(1, 1, 8'hE1, 1, 3, 8'hF3); tick();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_we_drop", rf_we, 0);
    chk("t5_pend", pend_mask, 0);
    chk("t5_ready", {alu_ready, ld_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wlog.delete();
    idle(5);
    chk("t5_no_write", wlog.size(), 0);

    // 6: random traffic obeying the hazard rule
    repeat (400) begin
      fr = ~m_pend();
      alu_valid = 1'b0; ld_valid = 1'b0;
      if (fr != '0 && $urandom_range(0, 3) != 0) begin
        alu_rd = AW'(pick(fr)); fr[alu_rd] = 1'b0;
        alu_data = DW'($urandom); alu_valid = 1'b1;
      end
      if (fr != '0 && $urandom_range(0, 1) != 0) begin
        ld_rd = AW'(pick(fr));
        ld_data = DW'($urandom); ld_valid = 1'b1;
      end
      tick();
    end
    idle(6);
    chk("t6_drained", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
